ps2_keyboard_rx: RTL and testbench

PS/2 keyboard front end: samples the raw `ps2_clk`/`ps2_data` pins and deserialises 11-bit frames. It checks start, odd parity and stop bits, buffers good bytes in a FIFO, and folds the `0xE0` (extended) and `0xF0` (break) prefixes into flags on a single key event. Each event carries one scan code on a valid/ready port; the scan-code-to-ASCII lookup stage downstream consumes it.

---
 rtl/ps2_keyboard_rx.sv | 207 ++++++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 keyboard frame receiver, byte FIFO and prefix-folding event decoder
module ps2_keyboard_rx #(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       code_ready,
    output logic       code_valid,
    output logic [7:0] scan_code,
    output logic       is_break,
    output logic       is_ext,
    output logic       frame_err,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);

    logic clk_s1_q, clk_s2_q, clk_s3_q;
    logic data_s1_q, data_s2_q;

    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          bad_q, bad_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          frame_err_q, frame_err_d;
    logic          push;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          fifo_empty, fifo_full, push_ok, pop;
    logic [7:0]    head;

    logic          code_valid_q, code_valid_d;
    logic [7:0]    scan_code_q, scan_code_d;
    logic          is_break_q, is_break_d;
    logic          is_ext_q, is_ext_d;
    logic          brk_pend_q, brk_pend_d;
    logic          ext_pend_q, ext_pend_d;
    logic          overflow_q, overflow_d;
    logic          slot_free;

    logic fall;
    logic data_bit;

    // Synchroniser flops idle high so a reset never fakes a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            clk_s3_q  <= 1'b1;
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
        end else begin
            clk_s1_q  <= ps2_clk;
            clk_s2_q  <= clk_s1_q;
            clk_s3_q  <= clk_s2_q;
            data_s1_q <= ps2_data;
            data_s2_q <= data_s1_q;
        end
    end

    assign fall     = clk_s3_q & ~clk_s2_q;
    assign data_bit = data_s2_q;

    // bad_q accumulates start and parity faults so the verdict lands on the stop bit.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        bad_d       = bad_q;
        wdog_d      = wdog_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        if (fall) begin
            wdog_d = '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = 4'd0;
                if (bad_q || !data_bit) begin
                    frame_err_d = 1'b1;
                end else begin
                    push = 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd0) begin
                    bad_d = data_bit;
                end else if (bit_cnt_q <= 4'd8) begin
                    shift_d = {data_bit, shift_q[7:1]};
                end else if (!(^{shift_q, data_bit})) begin
                    bad_d = 1'b1;
                end
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (wdog_q == WW'(TIMEOUT)) begin
                bit_cnt_d   = 4'd0;
                wdog_d      = '0;
                frame_err_d = 1'b1;
            end else begin
                wdog_d = wdog_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'd0;
            bad_q       <= 1'b0;
            wdog_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            bad_q       <= bad_d;
            wdog_q      <= wdog_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    // A pop in the same cycle frees the head slot, so a push into a full FIFO still fits.
    assign push_ok    = push && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign slot_free = !code_valid_q || code_ready;
    assign pop       = !fifo_empty && slot_free;

    always_comb begin
        code_valid_d = code_valid_q;
        scan_code_d  = scan_code_q;
        is_break_d   = is_break_q;
        is_ext_d     = is_ext_q;
        brk_pend_d   = brk_pend_q;
        ext_pend_d   = ext_pend_q;
        overflow_d   = overflow_q | (push && fifo_full && !pop);
        if (code_valid_q && code_ready) begin
            code_valid_d = 1'b0;
        end
        if (pop) begin
            case (head)
                8'hE0:   ext_pend_d = 1'b1;
                8'hF0:   brk_pend_d = 1'b1;
                default: begin
                    scan_code_d  = head;
                    is_ext_d     = ext_pend_q;
                    is_break_d   = brk_pend_q;
                    code_valid_d = 1'b1;
                    ext_pend_d   = 1'b0;
                    brk_pend_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_valid_q <= 1'b0;
            scan_code_q  <= 8'd0;
            is_break_q   <= 1'b0;
            is_ext_q     <= 1'b0;
            brk_pend_q   <= 1'b0;
            ext_pend_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            code_valid_q <= code_valid_d;
            scan_code_q  <= scan_code_d;
            is_break_q   <= is_break_d;
            is_ext_q     <= is_ext_d;
            brk_pend_q   <= brk_pend_d;
            ext_pend_q   <= ext_pend_d;
            overflow_q   <= overflow_d;
        end
    end

    assign code_valid = code_valid_q;
    assign scan_code  = scan_code_q;
    assign is_break   = is_break_q;
    assign is_ext     = is_ext_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb/tb_ps2_keyboard_rx.sv - self-checking bench for ps2_keyboard_rx against a key-event model
module tb_ps2_keyboard_rx;

    localparam int DEPTH = 4;
    localparam int TMO   = 200;
    localparam int HALF  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       code_ready = 1'b0;
    logic       code_valid;
    logic [7:0] scan_code;
    logic       is_break;
    logic       is_ext;
    logic       frame_err;
    logic       overflow;

    ps2_keyboard_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .code_ready (code_ready),
        .code_valid (code_valid),
        .scan_code  (scan_code),
        .is_break   (is_break),
        .is_ext     (is_ext),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int         n_pass = 0;
    int         n_total = 0;
    int         err_seen = 0;
    int         err_exp = 0;
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];
    logic       pend_ext = 1'b0;
    logic       pend_brk = 1'b0;
    logic       rand_ready = 1'b0;
    logic       prev_hold = 1'b0;
    logic [9:0] prev_ev = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    // Event recorder; also enforces that a stalled event never changes.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", {31'd0, code_valid}, 32'd1);
                check("hold_event", {22'd0, is_ext, is_break, scan_code}, {22'd0, prev_ev});
            end
            if (frame_err) err_seen++;
            if (code_valid && code_ready) got_q.push_back({is_ext, is_break, scan_code});
            prev_hold = code_valid && !code_ready;
            prev_ev   = {is_ext, is_break, scan_code};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) code_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF / 2) tick();
        ps2_clk = 1'b0;
        repeat (HALF) tick();
        ps2_clk = 1'b1;
        repeat (HALF / 2) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        logic [10:0] f;
        f = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(f[i]);
        repeat (HALF) tick();
    endtask

    task automatic model_byte(input logic [7:0] d);
        if (d == 8'hE0) pend_ext = 1'b1;
        else if (d == 8'hF0) pend_brk = 1'b1;
        else begin
            exp_q.push_back({pend_ext, pend_brk, d});
            pend_ext = 1'b0;
            pend_brk = 1'b0;
        end
    endtask

    task automatic send_good(input logic [7:0] d);
        send_frame(d, 1'b0, 1'b0);
        model_byte(d);
    endtask

    task automatic wait_events(input string tag);
        int n;
        code_ready = 1'b1;
        for (int i = 0; i < 3000 && got_q.size() < exp_q.size(); i++) tick();
        repeat (20) tick();
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_event"}, {22'd0, got_q[i]}, {22'd0, exp_q[i]});
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        pend_ext = 1'b0;
        pend_brk = 1'b0;
        got_q.delete();
        exp_q.delete();
        err_seen = 0;
        err_exp = 0;
        tick();
    endtask

    initial begin
        logic [10:0] f;
        logic [7:0]  d;
        logic        ex, br;

        repeat (3) tick();
        @(negedge clk);
        check("rst_valid", {31'd0, code_valid}, 32'd0);
        check("rst_code", {24'd0, scan_code}, 32'd0);
        check("rst_break", {31'd0, is_break}, 32'd0);
        check("rst_ext", {31'd0, is_ext}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        do_reset();

        // Single 0x1C frame with exact last-edge-to-valid latency.
        f = {1'b1, 1'b0, 8'h1C, 1'b0};
        for (int i = 0; i < 10; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        repeat (HALF / 2) tick();
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("lat_t1_valid", {31'd0, code_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("lat_t2_valid", {31'd0, code_valid}, 32'd1);
        check("lat_t2_code", {24'd0, scan_code}, 32'h1C);
        check("lat_t2_flags", {30'd0, is_break, is_ext}, 32'd0);
        #1;
        repeat (HALF) tick();
        ps2_clk = 1'b1;
        repeat (HALF) tick();
        model_byte(8'h1C);
        wait_events("make");

        send_good(8'hF0);
        send_good(8'h1C);
        wait_events("brk");

        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h74);
        send_good(8'h1C);
        wait_events("extbrk");

        send_good(8'hF0);
        send_good(8'hF0);
        send_good(8'h1C);
        wait_events("dupbrk");

        err_seen = 0;
        send_frame(8'h1C, 1'b1, 1'b0);
        send_frame(8'h55, 1'b0, 1'b1);
        repeat (20) tick();
        check("bad_ferr", err_seen, 32'd2);
        check("bad_noevent", got_q.size(), 32'd0);
        send_good(8'h21);
        wait_events("after_bad");

        err_seen = 0;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        repeat (TMO + 5) tick();
        check("tmo_ferr", err_seen, 32'd1);
        send_good(8'h32);
        wait_events("tmo");
        check("tmo_ferr_after", err_seen, 32'd1);

        code_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            send_frame(8'h10 + 8'(i), 1'b0, 1'b0);
            if (i < DEPTH + 1) model_byte(8'h10 + 8'(i));
            check("ovf_hold_valid", {31'd0, code_valid}, 32'd1);
            check("ovf_hold_code", {24'd0, scan_code}, 32'h10);
        end
        check("ovf_set", {31'd0, overflow}, 32'd1);
        wait_events("drain");
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        do_reset();
        check("ovf_cleared", {31'd0, overflow}, 32'd0);

        rand_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0);
                err_exp++;
            end else begin
                ex = 1'($urandom_range(0, 1));
                br = 1'($urandom_range(0, 1));
                do d = 8'($urandom_range(0, 255)); while (d == 8'hE0 || d == 8'hF0);
                if (ex) send_good(8'hE0);
                if (br) send_good(8'hF0);
                send_good(d);
            end
        end
        rand_ready = 1'b0;
        wait_events("rand");
        check("rand_ferr", err_seen, err_exp);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
